// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake block family.
// Holds default channel count/width and the round-robin wrap function.
package handshake_pkg;

   localparam int DEFAULT_N  = 4;
   localparam int DEFAULT_DW = 4;

   // Next round-robin position after ptr, wrapping explicitly at n so that
   // non-power-of-2 channel counts never reach an index >= n.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or above ptr,
// wrapping from N-1 to 0. Produces a one-hot grant plus its index.
module handshake_rr_pick
   import handshake_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] winner,
   output logic          any
);

   localparam logic [PW:0] N_W = (PW+1)'(N);

   logic [PW:0] sum;
   logic [PW:0] idx;

   // ptr < N and offset < N, so one conditional subtract is enough to wrap.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         idx = (sum >= N_W) ? (sum - N_W) : sum;
         if (!any && req[idx[PW-1:0]]) begin
            any                 = 1'b1;
            grant[idx[PW-1:0]]  = 1'b1;
            winner              = idx[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/handshake_rr_arb.sv
// Round-robin arbiter feeding one registered valid/ready output stage
// from N requester channels, with a per-channel enable mask.
module handshake_rr_arb
   import handshake_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int DW = DEFAULT_DW,
   parameter int PW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N-1:0]    valid_i,
   input  logic [N*DW-1:0] data_i,
   output logic [N-1:0]    ready_o,
   input  logic [N-1:0]    mask_i,
   output logic            valid_o,
   output logic [DW-1:0]   data_o,
   output logic [PW-1:0]   src_o,
   input  logic            ready_i
);

   // Handshake: a beat moves on a channel at a rising edge exactly when that
   // channel's valid and ready are both high; producers hold valid and data
   // until they see ready, and valid must never be derived from ready.

   logic          full;
   logic [PW-1:0] ptr;
   logic [N-1:0]  req;
   logic [N-1:0]  grant;
   logic [PW-1:0] winner;
   logic          any;
   logic          ld;
   logic [DW-1:0] win_data;

   assign req      = valid_i & mask_i;
   assign ld       = ~full | ready_i;
   assign valid_o  = full;
   assign win_data = data_i[int'(winner)*DW +: DW];

   // Gating with rstn keeps ready low for the whole reset pulse, even though
   // an empty stage would otherwise be loadable.
   assign ready_o  = (ld && rstn) ? grant : '0;

   handshake_rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .grant  (grant),
      .winner (winner),
      .any    (any)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full   <= 1'b0;
         data_o <= '0;
         src_o  <= '0;
         ptr    <= '0;
      end else if (ld) begin
         if (any) begin
            full   <= 1'b1;
            data_o <= win_data;
            src_o  <= winner;
            ptr    <= PW'(rr_next(int'(winner), N));
         end else begin
            full   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_handshake_rr_arb.sv
// Randomized and directed bench for handshake_rr_arb against a behavioural
// round-robin model and a beat scoreboard.
module tb_handshake_rr_arb;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int PW = 2;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    valid_i;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    ready_o;
   logic [N-1:0]    mask_i;
   logic            valid_o;
   logic [DW-1:0]   data_o;
   logic [PW-1:0]   src_o;
   logic            ready_i;

   handshake_rr_arb #(.N(N), .DW(DW)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .mask_i  (mask_i),
      .valid_o (valid_o),
      .data_o  (data_o),
      .src_o   (src_o),
      .ready_i (ready_i)
   );

   always #5 clk = ~clk;

   // requester-side state and reference model
   logic [N-1:0]       v;
   logic [DW-1:0]      d [N];
   logic [N-1:0]       last_ready;
   logic               m_full;
   logic [DW-1:0]      m_data;
   logic [PW-1:0]      m_src;
   int                 m_ptr;
   logic [PW+DW-1:0]   exp_q [$];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int find_winner(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic apply();
      valid_i = v;
      for (int k = 0; k < N; k++) data_i[k*DW +: DW] = d[k];
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_data = '0;
      m_src  = '0;
      m_ptr  = 0;
      exp_q.delete();
      last_ready = '0;
   endtask

   // Called just after a falling edge with inputs in place; returns at the next falling edge.
   task automatic cycle();
      logic [N-1:0] r;
      logic [N-1:0] exp_ready;
      int           w;
      logic         ld;
      apply();
      #1;
      r  = v & mask_i;
      w  = find_winner(r, m_ptr);
      ld = !m_full || ready_i;
      exp_ready = '0;
      if (ld && w >= 0) exp_ready[w] = 1'b1;
      check("ready_o", 32'(ready_o), 32'(exp_ready));
      check("valid_o", 32'(valid_o), 32'(m_full));
      if (m_full) begin
         check("data_hold", 32'(data_o), 32'(m_data));
         check("src_hold", 32'(src_o), 32'(m_src));
      end
      @(posedge clk);
      if (ld) begin
         if (w >= 0) begin
            m_full = 1'b1;
            m_data = d[w];
            m_src  = PW'(w);
            m_ptr  = (w + 1) % N;
            exp_q.push_back({PW'(w), d[w]});
         end else begin
            m_full = 1'b0;
         end
      end
      #1;
      check("valid_next", 32'(valid_o), 32'(m_full));
      if (exp_q.size() > 0) check("beat", 32'({src_o, data_o}), 32'(exp_q.pop_front()));
      last_ready = exp_ready;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with random inputs
      rstn    = 1'b0;
      v       = N'($urandom);
      for (int k = 0; k < N; k++) d[k] = DW'($urandom);
      mask_i  = N'($urandom);
      ready_i = 1'($urandom);
      apply();
      model_reset();
      #17;
      check("rst_valid", 32'(valid_o), 0);
      check("rst_ready", 32'(ready_o), 0);
      check("rst_data", 32'(data_o), 0);
      check("rst_src", 32'(src_o), 0);
      v = '0;
      apply();
      rstn = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("idle_valid", 32'(valid_o), 0);
         check("idle_data", 32'(data_o), 0);
      end

      // full rotation
      v = '1;
      for (int k = 0; k < N; k++) d[k] = DW'(4'hA + k);
      mask_i  = '1;
      ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("rot_valid", 32'(valid_o), 1);
         check("rot_src", 32'(src_o), i % N);
         check("rot_data", 32'(data_o), 4'hA + (i % N));
      end

      // backpressure: channel 2 loads, then stage is held for 3 cycles
      v = 4'b0100; d[2] = 4'h5;
      cycle();
      check("bp_src", 32'(src_o), 2);
      v = 4'b0001; d[0] = 4'h7; ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("bp_ready", 32'(ready_o), 0);
         check("bp_data", 32'(data_o), 4'h5);
         check("bp_src_hold", 32'(src_o), 2);
      end
      ready_i = 1'b1;
      apply();
      #1;
      check("bp_release_ready", 32'(ready_o), 32'(4'b0001));
      cycle();
      check("bp_reload_valid", 32'(valid_o), 1);
      check("bp_reload_data", 32'(data_o), 4'h7);
      check("bp_reload_src", 32'(src_o), 0);

      // masking: only 1 and 3 eligible, then all masked
      v = '1; mask_i = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("mask_src", 32'(src_o), (i % 2 == 0) ? 1 : 3);
      end
      mask_i = '0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("mask_off_valid", 32'(valid_o), 0);
      end

      // pointer skip and wrap
      mask_i = '1; v = 4'b1010; d[1] = 4'h1; d[3] = 4'h3;
      cycle();
      check("skip_src1", 32'(src_o), 1);
      cycle();
      check("skip_src3", 32'(src_o), 3);
      v = 4'b0011; d[0] = 4'h9;
      cycle();
      check("wrap_src0", 32'(src_o), 0);

      // reset mid-stream while the stage is held
      v = '1; ready_i = 1'b0;
      cycle();
      v = '0;
      apply();
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_valid", 32'(valid_o), 0);
      check("mid_rst_ready", 32'(ready_o), 0);
      check("mid_rst_data", 32'(data_o), 0);
      #1 rstn = 1'b1;
      model_reset();
      @(negedge clk);
      v = '1; ready_i = 1'b1;
      cycle();
      check("post_rst_src", 32'(src_o), 0);

      // randomized traffic with protocol-respecting requesters
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < N; k++) begin
            if (last_ready[k]) begin
               v[k] = 1'($urandom_range(0, 1));
               d[k] = DW'($urandom);
            end else if (!v[k]) begin
               v[k] = ($urandom_range(0, 2) == 0);
               d[k] = DW'($urandom);
            end
         end
         if ($urandom_range(0, 7) == 0) mask_i = N'($urandom);
         ready_i = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
